// File: rtl/otp_pkg.sv
// Shared constants, state/grant encodings and the response payload for the
// one-time-pad scheduler.
package otp_pkg;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    typedef enum logic {
        GR_ENC = 1'b0,
        GR_DEC = 1'b1
    } grant_t;

    typedef struct packed {
        logic [W-1:0]     data;
        logic [IDX_W-1:0] idx;
        logic             is_dec;
        logic             err;
    } rsp_t;

    // Number of occupied slots; CNT_W bits so a completely full store fits.
    function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/otp_rr_arb2.sv
// Two-requester round-robin arbiter: bit 0 is encrypt, bit 1 is decrypt.
// On a tie the requester that did not win last time is granted.
module otp_rr_arb2
    import otp_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    input  logic       grant_en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (grant_en) begin
            if (req == 2'b11) begin
                gnt = (last_grant == GR_DEC) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/otp_pad_scheduler.sv
// Sequences the shared one-time-pad store between an encrypt and a decrypt
// port; each stored pad is consumed by exactly one decrypt.
module otp_pad_scheduler
    import otp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_valid,
    output logic             enc_ready,
    input  logic [W-1:0]     enc_data,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [IDX_W-1:0] dec_idx,
    input  logic [W-1:0]     dec_data,
    input  logic [W-1:0]     pad_in,
    output logic             pad_adv,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic [IDX_W-1:0] rsp_idx,
    output logic             rsp_is_dec,
    output logic             rsp_err,
    output logic             full,
    output logic [CNT_W-1:0] used
);

    state_t           state_q, state_d;
    grant_t           last_grant_q, last_grant_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic             mem_we;
    rsp_t             rsp_q, rsp_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             full_int;

    // Slots are consumed strictly in order, so only the write-pointer slot matters.
    assign full_int = valid_q[wr_ptr_q];
    assign req      = {dec_valid, enc_valid & ~full_int};

    otp_rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant_en   (state_q == IDLE),
        .gnt        (gnt)
    );

    // Next-state and response capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_ptr_d     = wr_ptr_q;
        valid_d      = valid_q;
        rsp_d        = rsp_q;
        rsp_valid_d  = rsp_valid_q;
        mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt[0]) begin
                    mem_we            = 1'b1;
                    valid_d[wr_ptr_q] = 1'b1;
                    rsp_d.data        = pad_in ^ enc_data;
                    rsp_d.idx         = wr_ptr_q;
                    rsp_d.is_dec      = 1'b0;
                    rsp_d.err         = 1'b0;
                    wr_ptr_d          = wr_ptr_q + IDX_W'(1);
                    last_grant_d      = GR_ENC;
                    rsp_valid_d       = 1'b1;
                    state_d           = RESP;
                end else if (gnt[1]) begin
                    if (valid_q[dec_idx]) begin
                        rsp_d.data       = mem_q[dec_idx] ^ dec_data;
                        rsp_d.err        = 1'b0;
                        valid_d[dec_idx] = 1'b0;
                    end else begin
                        rsp_d.data = '0;
                        rsp_d.err  = 1'b1;
                    end
                    rsp_d.idx    = dec_idx;
                    rsp_d.is_dec = 1'b1;
                    last_grant_d = GR_DEC;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, valid bits and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GR_DEC;
            wr_ptr_q     <= '0;
            valid_q      <= '0;
            rsp_q        <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            valid_q      <= valid_d;
            rsp_q        <= rsp_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    // Pad storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[wr_ptr_q] <= pad_in;
        end
    end

    assign enc_ready  = gnt[0];
    assign dec_ready  = gnt[1];
    assign pad_adv    = gnt[0];
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_q.data;
    assign rsp_idx    = rsp_q.idx;
    assign rsp_is_dec = rsp_q.is_dec;
    assign rsp_err    = rsp_q.err;
    assign full       = full_int;
    assign used       = popcount(valid_q);

endmodule

// File: tb/tb_otp_pad_scheduler.sv
// Scoreboard bench for otp_pad_scheduler: directed requests push expected
// responses, a negedge monitor pops and compares on each response handshake.
module tb_otp_pad_scheduler;
    import otp_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             enc_valid;
    logic             enc_ready;
    logic [W-1:0]     enc_data;
    logic             dec_valid;
    logic             dec_ready;
    logic [IDX_W-1:0] dec_idx;
    logic [W-1:0]     dec_data;
    logic [W-1:0]     pad_in;
    logic             pad_adv;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [IDX_W-1:0] rsp_idx;
    logic             rsp_is_dec;
    logic             rsp_err;
    logic             full;
    logic [CNT_W-1:0] used;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    otp_pad_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .enc_valid  (enc_valid),
        .enc_ready  (enc_ready),
        .enc_data   (enc_data),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_idx    (dec_idx),
        .dec_data   (dec_data),
        .pad_in     (pad_in),
        .pad_adv    (pad_adv),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_idx    (rsp_idx),
        .rsp_is_dec (rsp_is_dec),
        .rsp_err    (rsp_err),
        .full       (full),
        .used       (used)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: compares every accepted response against the queue head.
    always @(negedge clk) begin
        rsp_t got;
        rsp_t want;
        if (!rst && rsp_valid && rsp_ready) begin
            got = {rsp_data, rsp_idx, rsp_is_dec, rsp_err};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got data=%h idx=%0d dec=%b err=%b, nothing expected",
                         rsp_data, rsp_idx, rsp_is_dec, rsp_err);
            end else begin
                want = exp_q.pop_front();
                chk("rsp{data,idx,is_dec,err}", 32'(got), 32'(want));
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_enc(input logic [W-1:0] pad, input logic [W-1:0] data,
                          input logic [IDX_W-1:0] idx, input bit push);
        int   waited;
        rsp_t e;
        waited    = 0;
        enc_valid = 1'b1;
        enc_data  = data;
        pad_in    = pad;
        #1;
        while (!enc_ready && waited < 20) begin
            @(posedge clk); #2;
            waited++;
        end
        if (!enc_ready) begin
            chk("enc_ready_timeout", 32'(enc_ready), 32'd1);
            enc_valid = 1'b0;
            return;
        end
        chk("enc_pad_adv", 32'(pad_adv), 32'd1);
        if (push) begin
            e = {W'(pad ^ data), idx, 1'b0, 1'b0};
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        enc_valid = 1'b0;
    endtask

    task automatic do_dec(input logic [IDX_W-1:0] idx, input logic [W-1:0] data,
                          input logic [W-1:0] exp_data, input logic exp_err);
        int   waited;
        rsp_t e;
        waited    = 0;
        dec_valid = 1'b1;
        dec_idx   = idx;
        dec_data  = data;
        #1;
        while (!dec_ready && waited < 20) begin
            @(posedge clk); #2;
            waited++;
        end
        if (!dec_ready) begin
            chk("dec_ready_timeout", 32'(dec_ready), 32'd1);
            dec_valid = 1'b0;
            return;
        end
        chk("dec_no_pad_adv", 32'(pad_adv), 32'd0);
        e = {exp_data, idx, 1'b1, exp_err};
        exp_q.push_back(e);
        @(posedge clk); #1;
        dec_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (rsp_valid) chk("idle_timeout", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int   grants;
        int   n;
        rsp_t e;

        rst       = 1'b1;
        enc_valid = 1'b0;
        enc_data  = '0;
        dec_valid = 1'b0;
        dec_idx   = '0;
        dec_data  = '0;
        pad_in    = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_enc_ready", 32'(enc_ready), 32'd0);
        chk("reset_used", 32'(used), 32'd0);
        chk("reset_full", 32'(full), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic encrypt: 0x5A ^ 0x3C = 0x66 in slot 0
        do_enc(8'h5A, 8'h3C, 3'd0, 1'b1);
        chk("basic_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("basic_used", 32'(used), 32'd1);
        wait_idle();

        // Round trip, then one-time use
        do_dec(3'd0, 8'h66, 8'h3C, 1'b0);
        chk("dec_used", 32'(used), 32'd0);
        wait_idle();
        do_dec(3'd0, 8'h66, 8'h00, 1'b1);
        wait_idle();

        // Backpressure: slot 1, 0x11 ^ 0x22 = 0x33
        rsp_ready = 1'b0;
        do_enc(8'h11, 8'h22, 3'd1, 1'b1);
        dec_valid = 1'b1;
        dec_idx   = 3'd3;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h33);
            chk("bp_rsp_idx", 32'(rsp_idx), 32'd1);
            chk("bp_readies", 32'({enc_ready, dec_ready}), 32'd0);
            @(posedge clk); #1;
        end
        dec_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", 32'(rsp_valid), 32'd0);

        // Reset while a response is pending (slot 2, not expected on the bus)
        rsp_ready = 1'b0;
        do_enc(8'h01, 8'h02, 3'd2, 1'b0);
        chk("prereset_used", 32'(used), 32'd2);
        rst = 1'b1;
        #1;
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_used", 32'(used), 32'd0);
        chk("midreset_full", 32'(full), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;

        // Fill all slots: pad 0x10+i ^ 0xA0 = 0xB0+i in slot i
        for (int i = 0; i < 8; i++) begin
            do_enc(W'(8'h10 + i), 8'hA0, IDX_W'(i), 1'b1);
            wait_idle();
        end
        chk("fill_used", 32'(used), 32'd8);
        chk("fill_full", 32'(full), 32'd1);
        enc_valid = 1'b1;
        enc_data  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_enc_stall", 32'(enc_ready), 32'd0);
            @(posedge clk); #1;
        end
        enc_valid = 1'b0;

        // Free slot 0 (pad 0x10), encrypt wraps into it
        do_dec(3'd0, 8'hB0, 8'hA0, 1'b0);
        wait_idle();
        chk("wrap_full_clear", 32'(full), 32'd0);
        chk("wrap_used", 32'(used), 32'd7);
        do_enc(8'h77, 8'h00, 3'd0, 1'b1);
        wait_idle();
        chk("wrap_full_again", 32'(full), 32'd1);
        chk("wrap_used_full", 32'(used), 32'd8);

        // Simultaneous requests after reset: ENC, DEC, ENC, DEC
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        e = {8'hCC, 3'd0, 1'b0, 1'b0}; exp_q.push_back(e);
        e = {8'h0F, 3'd0, 1'b1, 1'b0}; exp_q.push_back(e);
        e = {8'hCC, 3'd1, 1'b0, 1'b0}; exp_q.push_back(e);
        e = {8'h00, 3'd0, 1'b1, 1'b1}; exp_q.push_back(e);
        enc_valid = 1'b1;
        enc_data  = 8'h0F;
        pad_in    = 8'hC3;
        dec_valid = 1'b1;
        dec_idx   = 3'd0;
        dec_data  = 8'hCC;
        grants    = 0;
        n         = 0;
        while (grants < 4 && n < 40) begin
            #1;
            if (enc_ready || dec_ready) begin
                chk("rr_one_hot", 32'(enc_ready & dec_ready), 32'd0);
                chk($sformatf("rr_grant%0d_is_dec", grants), 32'(dec_ready), 32'(grants % 2));
                grants++;
            end
            @(posedge clk); #1;
            n++;
        end
        enc_valid = 1'b0;
        dec_valid = 1'b0;
        if (grants < 4) chk("rr_grant_timeout", 32'(grants), 32'd4);
        wait_idle();
        chk("rr_used", 32'(used), 32'd1);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/otp_pad_scheduler.md
Name: otp_pad_scheduler

Overview:
Controller that sequences the shared one-time-pad store between two requesters: an encrypt port and a decrypt port. On encrypt it draws a fresh pad from the external LFSR, stores it in the next slot, and returns ciphertext plus the slot index. On decrypt it reads a stored pad, returns plaintext, and invalidates the slot so each pad is used only once. It sits between the top-level IO glue and the PRNG/pad memory, with round-robin arbitration when both ports request at once.

Parameters:
W, 8, data/pad width in bits
DEPTH, 8, number of pad slots (power of 2)
IDX_W, 3, slot index width, equal to log2(DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous and active-high
enc_valid  in  1  encrypt request
enc_ready  out  1  encrypt request accepted this cycle
enc_data  in  W  plaintext to encrypt
dec_valid  in  1  decrypt request
dec_ready  out  1  decrypt request accepted this cycle
dec_idx  in  IDX_W  slot holding the pad for decrypt
dec_data  in  W  ciphertext to decrypt
pad_in  in  W  current PRNG output
pad_adv  out  1  one-cycle pulse: advance the PRNG
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_data  out  W  ciphertext or plaintext
rsp_idx  out  IDX_W  slot used
rsp_is_dec  out  1  1 means the response is for a decrypt
rsp_err  out  1  decrypt addressed an empty slot
full  out  1  slot at the write pointer is still occupied
used  out  IDX_W+1  number of valid slots

Behaviour:
- Reset (asynchronous): all outputs are 0. Reset clears state=IDLE, wr_ptr=0, valid[]=0, pad memory=0, and last_grant=DEC, so encrypt wins the first tie.
- FSM has two states:
  - IDLE: the arbiter picks at most one eligible requester.
  - RESP: rsp_* registers are held stable while rsp_valid=1. RESP→IDLE when rsp_ready=1.
- Eligibility:
  - enc is eligible when enc_valid && !full.
  - dec is eligible when dec_valid.
- Arbitration:
  - If only one requester is eligible, it is granted.
  - If both are eligible, the one not granted last is granted.
  - last_grant updates only on a grant.
- enc_ready and dec_ready are combinational, asserted only in IDLE and only for the granted port. Both are never high together. Both are 0 in RESP.
- Encrypt accept (enc_valid && enc_ready at the clock edge):
  - mem[wr_ptr] <= pad_in; valid[wr_ptr] <= 1.
  - rsp_data <= pad_in ^ enc_data; rsp_idx <= wr_ptr; rsp_is_dec <= 0; rsp_err <= 0.
  - wr_ptr increments, wrapping DEPTH-1→0.
  - pad_adv=1 during the accept cycle only.
  - Go to RESP.
- Decrypt accept:
  - If valid[dec_idx]=1: rsp_data <= mem[dec_idx] ^ dec_data; valid[dec_idx] <= 0; rsp_err <= 0.
  - Else: rsp_data <= 0; rsp_err <= 1; no state change.
  - rsp_idx <= dec_idx; rsp_is_dec <= 1. Go to RESP.
- Latency and throughput:
  - Response appears 1 cycle after accept (rsp_valid=1 the cycle after the handshake).
  - Peak rate is one operation per 2 cycles with rsp_ready tied high.
- full = valid[wr_ptr]. Encrypt stalls (enc_ready=0) even if other slots are free, because slots are consumed strictly in order. A decrypt is still served while full.
- used = popcount(valid). It updates in the same edge as the accept and never exceeds DEPTH.
- Decrypt of the slot just written: mem and valid are updated at the accept edge, and the next accept is at least 2 cycles later, so no forwarding is needed.
- Reset asserted during RESP: the response is dropped, rsp_valid drops immediately (asynchronously), and all slots are lost.
- Request inputs are ignored outside the grant. Requesters must hold valid and data stable until ready.

Decomposition:
- Shared package otp_pkg holds:
  - W, DEPTH, IDX_W localparams
  - state enum {IDLE, RESP}
  - grant enum {GR_ENC, GR_DEC}
- One sub-module, otp_rr_arb2: 2-requester round-robin arbiter. Inputs are req[1:0], last_grant, and grant_en; output is one-hot gnt[1:0]. Pad memory, valid bits, and the FSM live in otp_pad_scheduler.

Test Plan:
- Basic encrypt: pad_in=0x5A, enc_data=0x3C, rsp_ready=1 → enc_ready=1 in cycle 0, pad_adv=1 in cycle 0; next cycle rsp_valid=1, rsp_data=0x66, rsp_idx=0, rsp_is_dec=0, used=1.
- Decrypt round-trip and one-time use:
  - After the basic encrypt, dec_idx=0, dec_data=0x66 → rsp_data=0x3C, rsp_err=0, used=0.
  - Repeat the same decrypt → rsp_err=1, rsp_data=0x00.
- Fill and wrap:
  - 8 encrypts with no decrypts → rsp_idx runs 0..7, used=8, full=1, enc_ready stays 0.
  - Decrypt idx 0 → full=0; next encrypt gets rsp_idx=0.
- Simultaneous requests: enc_valid=dec_valid=1 held, slots available → grants alternate ENC, DEC, ENC, DEC, with ENC first after reset.
- Backpressure: rsp_ready=0 for 5 cycles after an accept → rsp_* stable and both readies 0 for those cycles; rsp_ready=1 → IDLE next cycle.
- Reset mid-operation: assert rst while rsp_valid=1 → rsp_valid=0 immediately, used=0, full=0; the first post-reset encrypt gets rsp_idx=0.
